// File: rtl/rob_pkg.sv
// Shared reorder-buffer types: sizing, branch tag encodings and the per-entry record.
package rob_pkg;
  localparam int ROB_DEPTH = 32;
  localparam int ROB_ID_W  = 5;

  localparam logic [1:0] BT_NONE = 2'b00;
  localparam logic [1:0] BT_NT   = 2'b01;
  localparam logic [1:0] BT_T    = 2'b10;

  typedef struct packed {
    logic        valid;
    logic        done;
    logic [4:0]  regaddr;
    logic [31:0] pc;
    logic [1:0]  tag;
    logic [31:0] data;
    logic        cond;
  } rob_entry_t;
endpackage

// File: rtl/rob.sv
// Reorder buffer: in-order allocate, out-of-order CDB writeback, in-order
// presentation of the oldest completed entry to commit; flush empties it.
module rob
  import rob_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int ID_W  = ROB_ID_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            alloc_en_i,
  input  logic [4:0]      alloc_regaddr_i,
  input  logic [31:0]     alloc_pc_i,
  input  logic [1:0]      alloc_branch_tag_i,
  output logic            alloc_rdy_o,
  output logic [ID_W-1:0] alloc_id_o,
  input  logic            wb_en_i,
  input  logic [ID_W-1:0] wb_id_i,
  input  logic [31:0]     wb_data_i,
  input  logic            wb_cond_i,
  input  logic [ID_W-1:0] qry_id_i,
  output logic            qry_ready_o,
  output logic [31:0]     qry_data_o,
  input  logic            commit_rdy_i,
  output logic            en_o,
  output logic [4:0]      regaddr_o,
  output logic [ID_W-1:0] id_o,
  output logic [31:0]     data_o,
  output logic [31:0]     pc_o,
  output logic [1:0]      branch_tag_o,
  output logic            cond_o
);
  localparam logic [ID_W:0] FULL = (ID_W+1)'(DEPTH);

  rob_entry_t      ent_q [DEPTH];
  logic [ID_W-1:0] head_q, tail_q;
  logic [ID_W:0]   cnt_q;

  rob_entry_t head_e, qry_e;
  logic       alloc_fire, wb_fire, ret_fire, qry_hit;

  assign head_e = ent_q[head_q];
  assign qry_e  = ent_q[qry_id_i];

  // Ready comes only from the registered count, so a full buffer never
  // accepts an alloc on the strength of a same-cycle retire.
  assign alloc_rdy_o = !rst && (cnt_q != FULL);
  assign alloc_id_o  = rst ? '0 : tail_q;

  assign en_o         = !rst && !flush_i && head_e.valid && head_e.done;
  assign regaddr_o    = en_o ? head_e.regaddr : '0;
  assign id_o         = en_o ? head_q         : '0;
  assign data_o       = en_o ? head_e.data    : '0;
  assign pc_o         = en_o ? head_e.pc      : '0;
  assign branch_tag_o = en_o ? head_e.tag     : '0;
  assign cond_o       = en_o ? head_e.cond    : 1'b0;

  assign alloc_fire = alloc_en_i && alloc_rdy_o;
  assign wb_fire    = wb_en_i && ent_q[wb_id_i].valid;
  assign ret_fire   = en_o && commit_rdy_i;

  // Operand lookup sees a same-cycle CDB result before it lands in the array.
  assign qry_hit     = wb_en_i && (wb_id_i == qry_id_i);
  assign qry_ready_o = !rst && (qry_hit || (qry_e.valid && qry_e.done));
  assign qry_data_o  = rst ? '0 : (qry_hit ? wb_data_i : qry_e.data);

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i].valid <= 1'b0;
        ent_q[i].done  <= 1'b0;
      end
    end else begin
      if (wb_fire) begin
        ent_q[wb_id_i].done <= 1'b1;
        ent_q[wb_id_i].data <= wb_data_i;
        ent_q[wb_id_i].cond <= wb_cond_i;
      end
      if (alloc_fire) begin
        ent_q[tail_q] <= '{valid: 1'b1, done: 1'b0, regaddr: alloc_regaddr_i,
                           pc: alloc_pc_i, tag: alloc_branch_tag_i,
                           data: 32'h0, cond: 1'b0};
        tail_q <= tail_q + 1'b1;
      end
      if (ret_fire) begin
        ent_q[head_q].valid <= 1'b0;
        head_q <= head_q + 1'b1;
      end
      cnt_q <= cnt_q + (ID_W+1)'(alloc_fire) - (ID_W+1)'(ret_fire);
    end
  end
endmodule

// File: tb/tb_rob.sv
// Self-checking bench for rob: reference model plus an in-order commit scoreboard.
module tb_rob;
  import rob_pkg::*;
  localparam int D = ROB_DEPTH;
  localparam int W = ROB_ID_W;

  logic         clk = 1'b0;
  logic         rst, flush_i, alloc_en_i, alloc_rdy_o, wb_en_i, wb_cond_i;
  logic [4:0]   alloc_regaddr_i, regaddr_o;
  logic [31:0]  alloc_pc_i, wb_data_i, qry_data_o, data_o, pc_o;
  logic [1:0]   alloc_branch_tag_i, branch_tag_o;
  logic [W-1:0] alloc_id_o, wb_id_i, qry_id_i, id_o;
  logic         qry_ready_o, commit_rdy_i, en_o, cond_o;

  always #5 clk = ~clk;

  rob #(.DEPTH(D), .ID_W(W)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .alloc_en_i(alloc_en_i), .alloc_regaddr_i(alloc_regaddr_i), .alloc_pc_i(alloc_pc_i),
    .alloc_branch_tag_i(alloc_branch_tag_i), .alloc_rdy_o(alloc_rdy_o), .alloc_id_o(alloc_id_o),
    .wb_en_i(wb_en_i), .wb_id_i(wb_id_i), .wb_data_i(wb_data_i), .wb_cond_i(wb_cond_i),
    .qry_id_i(qry_id_i), .qry_ready_o(qry_ready_o), .qry_data_o(qry_data_o),
    .commit_rdy_i(commit_rdy_i), .en_o(en_o), .regaddr_o(regaddr_o), .id_o(id_o),
    .data_o(data_o), .pc_o(pc_o), .branch_tag_o(branch_tag_o), .cond_o(cond_o)
  );

  int errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference state
  logic        m_v [D];
  logic        m_d [D];
  logic [31:0] m_data [D];
  logic        m_cond [D];
  int          m_head, m_tail, m_cnt;

  typedef struct {
    int          id;
    logic [4:0]  ra;
    logic [31:0] pc;
    logic [1:0]  tag;
  } rec_t;
  rec_t sb[$];

  // One clock: compare at negedge against pre-edge model state, update model at posedge.
  task automatic tick();
    bit do_al, do_wb, do_rt;
    rec_t r;
    @(negedge clk);
    if (rst) begin
      chk("rst_alloc_rdy", alloc_rdy_o, 0);
      chk("rst_alloc_id", alloc_id_o, 0);
      chk("rst_en", en_o, 0);
      chk("rst_qry_ready", qry_ready_o, 0);
    end else begin
      chk("en_o", en_o, !flush_i && m_v[m_head] && m_d[m_head]);
      chk("alloc_rdy", alloc_rdy_o, m_cnt < D);
      do_rt = !flush_i && m_v[m_head] && m_d[m_head] && commit_rdy_i;
      if (do_rt) begin
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          r = sb.pop_front();
          chk("commit_id", id_o, r.id);
          chk("commit_data", data_o, m_data[r.id]);
          chk("commit_regaddr", regaddr_o, r.ra);
          chk("commit_pc", pc_o, r.pc);
          chk("commit_tag", branch_tag_o, r.tag);
          chk("commit_cond", cond_o, m_cond[r.id]);
        end
      end
      do_al = alloc_en_i && (m_cnt < D);
      if (do_al) chk("alloc_id", alloc_id_o, m_tail);
      do_wb = wb_en_i && m_v[wb_id_i];
    end
    @(posedge clk);
    if (rst || flush_i) begin
      for (int i = 0; i < D; i++) begin m_v[i] = 0; m_d[i] = 0; end
      m_head = 0; m_tail = 0; m_cnt = 0;
      sb.delete();
    end else begin
      if (do_wb) begin
        m_d[wb_id_i] = 1; m_data[wb_id_i] = wb_data_i; m_cond[wb_id_i] = wb_cond_i;
      end
      if (do_al) begin
        m_v[m_tail] = 1; m_d[m_tail] = 0;
        sb.push_back('{m_tail, alloc_regaddr_i, alloc_pc_i, alloc_branch_tag_i});
        m_tail = (m_tail + 1) % D; m_cnt++;
      end
      if (do_rt) begin
        m_v[m_head] = 0; m_head = (m_head + 1) % D; m_cnt--;
      end
    end
    #1;
  endtask

  task automatic wb(input int id, input logic [31:0] d, input logic c);
    wb_en_i = 1; wb_id_i = W'(id); wb_data_i = d; wb_cond_i = c;
    tick();
    wb_en_i = 0;
  endtask

  initial begin
    rst = 1; flush_i = 0; alloc_en_i = 0; alloc_regaddr_i = 0; alloc_pc_i = 0;
    alloc_branch_tag_i = BT_NONE; wb_en_i = 0; wb_id_i = 0; wb_data_i = 0; wb_cond_i = 0;
    qry_id_i = 0; commit_rdy_i = 0;
    tick(); tick();
    rst = 0; #1;
    chk("post_rst_rdy", alloc_rdy_o, 1);
    chk("post_rst_id", alloc_id_o, 0);
    chk("post_rst_en", en_o, 0);

    // Out-of-order completion, in-order commit
    alloc_en_i = 1;
    for (int i = 0; i < 3; i++) begin
      alloc_regaddr_i = 5'(i + 1); alloc_pc_i = 32'h100 + 32'(4 * i); tick();
    end
    alloc_en_i = 0; tick();
    wb(1, 32'hAA, 0); #1;
    chk("head_not_done", en_o, 0);
    wb(0, 32'h55, 0); #1;
    chk("head_en", en_o, 1);
    chk("head_id0", id_o, 0);
    chk("head_data0", data_o, 32'h55);
    commit_rdy_i = 1; tick();
    chk("head_id1", id_o, 1);
    chk("head_data1", data_o, 32'hAA);
    tick();
    commit_rdy_i = 0;
    wb(2, 32'h33, 1);
    commit_rdy_i = 1; tick(); commit_rdy_i = 0;

    // Fill to full, overflow alloc ignored, wrap to id 0
    rst = 1; tick(); rst = 0;
    alloc_en_i = 1;
    for (int i = 0; i < D; i++) begin
      alloc_regaddr_i = 5'(i); alloc_pc_i = 32'(i * 4); tick();
    end
    #1 chk("full_rdy", alloc_rdy_o, 0);
    tick();
    alloc_en_i = 0;
    wb(0, 32'h100, 0);
    commit_rdy_i = 1; tick(); commit_rdy_i = 0; #1;
    chk("after_retire_rdy", alloc_rdy_o, 1);
    chk("wrap_id", alloc_id_o, 0);
    alloc_en_i = 1; tick(); alloc_en_i = 0;
    flush_i = 1; tick(); flush_i = 0;

    // Simultaneous alloc and retire at count 5
    alloc_en_i = 1;
    for (int i = 0; i < 5; i++) begin
      alloc_regaddr_i = 5'(i + 8); alloc_pc_i = 32'h200 + 32'(i); tick();
    end
    alloc_en_i = 0;
    for (int i = 0; i < 3; i++) wb(i, 32'h10 + 32'(i), 0);
    alloc_en_i = 1; commit_rdy_i = 1; #1;
    chk("ar_tail_pre", alloc_id_o, 5);
    chk("ar_head_pre", id_o, 0);
    tick();
    alloc_en_i = 0; commit_rdy_i = 0; #1;
    chk("ar_tail_post", alloc_id_o, 6);
    chk("ar_head_post", id_o, 1);

    // Query with same-cycle writeback bypass
    qry_id_i = 3; wb_en_i = 1; wb_id_i = 3; wb_data_i = 32'h1234; wb_cond_i = 0; #1;
    chk("qry_bypass_rdy", qry_ready_o, 1);
    chk("qry_bypass_data", qry_data_o, 32'h1234);
    tick();
    wb_en_i = 0; #1;
    chk("qry_stored_rdy", qry_ready_o, 1);
    chk("qry_stored_data", qry_data_o, 32'h1234);
    qry_id_i = 4; #1;
    chk("qry_not_done", qry_ready_o, 0);

    // Branch at head, then flush with concurrent alloc/wb/commit
    flush_i = 1; tick(); flush_i = 0;
    alloc_en_i = 1; alloc_regaddr_i = 0; alloc_pc_i = 32'h8000_0040; alloc_branch_tag_i = BT_T; tick();
    alloc_regaddr_i = 7; alloc_pc_i = 32'h44; alloc_branch_tag_i = BT_NONE; tick();
    alloc_en_i = 0;
    wb(0, 32'h0, 0); #1;
    chk("br_en", en_o, 1);
    chk("br_pc", pc_o, 32'h8000_0040);
    chk("br_tag", branch_tag_o, BT_T);
    chk("br_cond", cond_o, 0);
    flush_i = 1; alloc_en_i = 1; alloc_regaddr_i = 9; commit_rdy_i = 1;
    wb_en_i = 1; wb_id_i = 1; wb_data_i = 32'hDEAD; #1;
    chk("flush_masks_en", en_o, 0);
    tick();
    flush_i = 0; alloc_en_i = 0; commit_rdy_i = 0; wb_en_i = 0; #1;
    chk("flush_id", alloc_id_o, 0);
    chk("flush_en", en_o, 0);
    chk("flush_rdy", alloc_rdy_o, 1);
    qry_id_i = 1; #1 chk("flush_q1", qry_ready_o, 0);
    qry_id_i = 2; #1 chk("flush_q2", qry_ready_o, 0);
    alloc_en_i = 1; tick(); alloc_en_i = 0; tick();
    chk("flush_no_done", en_o, 0);

    // Reset mid-operation with count 7
    alloc_en_i = 1;
    for (int i = 0; i < 6; i++) tick();
    alloc_en_i = 0;
    wb(1, 32'h77, 1);
    rst = 1; qry_id_i = 1; wb_en_i = 1; wb_id_i = 1; wb_data_i = 32'h99; #1;
    chk("rst_force_rdy", alloc_rdy_o, 0);
    chk("rst_force_qry", qry_ready_o, 0);
    chk("rst_force_qdata", qry_data_o, 0);
    tick();
    rst = 0; wb_en_i = 0; #1;
    chk("rst2_rdy", alloc_rdy_o, 1);
    chk("rst2_id", alloc_id_o, 0);
    chk("rst2_en", en_o, 0);
    chk("rst2_qry", qry_ready_o, 0);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/rob.md
Name: rob

Overview:
- Reorder buffer directly upstream of the commit stage.
- Allocates one entry per dispatched instruction in program order and captures results from the common data bus.
- Presents the oldest completed entry to commit, one per cycle.
- Clears completely when commit raises its mispredict restart (rst_c).

Parameters:
DEPTH, 32, number of entries (power of two).
ID_W, 5, entry-index width; equals log2(DEPTH) and matches the 5-bit id used by commit/regfile.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
flush_i  in  1  restart from commit (rst_c); empties the buffer
alloc_en_i  in  1  dispatch requests an entry this cycle
alloc_regaddr_i  in  5  destination register (0 = no write)
alloc_pc_i  in  32  redirect PC used if the branch mispredicts
alloc_branch_tag_i  in  2  00 non-branch, 01 predicted not-taken, 10 predicted taken
alloc_rdy_o  out  1  entry available (count < DEPTH)
alloc_id_o  out  ID_W  index granted to the current request (= tail)
wb_en_i  in  1  CDB result valid
wb_id_i  in  ID_W  entry completing
wb_data_i  in  32  result value
wb_cond_i  in  1  resolved branch condition
qry_id_i  in  ID_W  operand lookup index
qry_ready_o  out  1  queried entry valid and done (incl. same-cycle wb)
qry_data_o  out  32  queried entry data (wb bypassed)
commit_rdy_i  in  1  commit accepts head this cycle
en_o  out  1  head valid and done
regaddr_o  out  5  head destination
id_o  out  ID_W  head index
data_o  out  32  head result
pc_o  out  32  head redirect PC
branch_tag_o  out  2  head branch tag
cond_o  out  1  head resolved condition

Behaviour:
- State: per-entry valid, done, regaddr, pc, tag, data, cond; head and tail pointers (ID_W bits); count (ID_W+1 bits).
- Reset (rst high at a clock edge):
  - Clear head, tail, count and every valid/done bit.
  - While rst is high, all outputs are forced to 0, including alloc_rdy_o.
  - First cycle after reset: alloc_rdy_o=1, alloc_id_o=0, en_o=0.
- Allocate:
  - Fires when alloc_en_i && alloc_rdy_o.
  - Writes the entry at tail with valid=1, done=0; tail increments modulo DEPTH.
  - alloc_en_i while full is ignored and nothing changes.
- Writeback:
  - Fires when wb_en_i and entry wb_id_i is valid; sets done=1 and stores data and cond.
  - wb to an invalid entry is ignored.
- Head presentation:
  - Combinational from the head entry: en_o = valid[head] && done[head] && !flush_i.
  - When en_o=0, the data outputs are 0.
- Retire:
  - Fires when en_o && commit_rdy_i; clears valid[head] and increments head modulo DEPTH.
  - Throughput is one retire per cycle.
  - A wb in cycle N makes the entry retirable in cycle N+1 (no wb-to-head bypass).
- Count:
  - count += alloc - retire in the same cycle.
  - Simultaneous alloc and retire leaves count unchanged.
  - alloc_rdy_o depends only on the registered count; when full, a same-cycle retire does not enable an alloc.
- Query:
  - Combinational lookup.
  - If wb_en_i && wb_id_i==qry_id_i, return wb_data_i with ready=1.
  - Otherwise return the stored data; ready = valid && done.
- Flush:
  - Highest priority after rst.
  - Clears all valid/done bits and sets head=tail=count=0.
  - Same-cycle alloc, wb and retire are discarded.
  - The entry that caused the mispredict has already been handed to commit this cycle; commit writes it to the regfile, the ROB does not retire it again.
- Wrap-around: pointers wrap DEPTH-1 -> 0. Full is count==DEPTH; empty is count==0, since head==tail is ambiguous.
- No combinational path from commit_rdy_i to alloc_rdy_o.

Decomposition:
- Package rob_pkg holds:
  - ROB_DEPTH and ROB_ID_W.
  - Branch tag constants BT_NONE=2'b00, BT_NT=2'b01, BT_T=2'b10.
  - The entry struct typedef.
- No sub-module; the entry array and pointer logic stay in one module.

Test Plan:
- Reset then 3 allocs (regaddr 1,2,3) -> alloc_id_o 0,1,2; en_o stays 0 until a wb. wb id1 data 0xAA first -> en_o still 0 (head 0 not done). Then wb id0 0x55 -> next cycle en_o=1, id_o=0, data_o=0x55; with commit_rdy_i=1 the next head is id1 with 0xAA.
- Fill 32 entries -> alloc_rdy_o=0 and a 33rd alloc_en_i is ignored. Retire one -> alloc_rdy_o=1; the next alloc gets id 0 (wrap).
- Simultaneous alloc+retire at count=5 -> count stays 5, tail and head each advance by 1.
- Query id3 while wb_en_i writes id3 0x1234 in the same cycle -> qry_ready_o=1, qry_data_o=0x1234.
- Branch entry tag=10 with wb cond=0 reaches head -> en_o=1, pc_o=alloc_pc. Assert flush_i with concurrent alloc and wb -> next cycle count=0, en_o=0, alloc_id_o=0, and the discarded alloc/wb have left no trace.
- Assert rst mid-operation with count=7 -> next cycle all outputs at reset values and alloc_rdy_o=1.
